// File: rtl/qspi_shift_engine.sv
// QSPI byte-slot shift engine: SPI mode 0, single/quad IO, one CS_n frame spanning consecutive slots.
// Each slot is a run of SCLK (high, low) half-periods; a frame adds a setup low phase up front and a hold low phase at the end.
module qspi_shift_engine #(
  parameter int CLK_DIV      = 2,
  parameter int DUMMY_CYCLES = 8,
  parameter int CS_HIGH_CYC  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  input  logic       i_rw,
  input  logic       i_q_mode,
  input  logic       i_dummy,
  output logic       o_ready,
  output logic       o_dload,
  output logic       o_dval,
  output logic [7:0] o_rx_data,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic [3:0] o_io_out,
  output logic [3:0] o_io_oe,
  input  logic [3:0] i_io_in
);
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_DUMMY, S_HOLD, S_CSHIGH} state_t;

  localparam int MAXN = (DUMMY_CYCLES > 8) ? DUMMY_CYCLES : 8;
  localparam int HW   = $clog2(2 * MAXN);
  localparam int CMAX = (CLK_DIV > CS_HIGH_CYC) ? CLK_DIV : CS_HIGH_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CSH_LAST = CW'(CS_HIGH_CYC - 1);

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [HW-1:0]   r_half;
  logic            r_setup, r_sclk, r_rw, r_q, r_dval;
  logic [7:0]      r_sh, r_rx_data;
  logic [6:0]      r_rx;

  logic            w_busy, w_tick, w_bound, w_ld, w_rise, w_fall, w_final;
  logic            w_rx_rw, w_rx_q;
  logic [HW-1:0]   w_last_half;
  logic [7:0]      w_rx_shift;
  logic [3:0]      w_oe;

  assign w_busy = (r_state == S_SHIFT) || (r_state == S_DUMMY);
  assign w_tick = (r_cnt == DIV_LAST);

  always_comb begin
    if (r_state == S_DUMMY) w_last_half = HW'(2 * DUMMY_CYCLES - 1);
    else if (r_q)           w_last_half = HW'(3);
    else                    w_last_half = HW'(15);
  end

  // Byte boundary: last clk of the final SCLK low phase of a slot.
  assign w_bound = w_busy && w_tick && !r_setup && (r_half == w_last_half);
  assign w_ld    = !rst && i_start && ((r_state == S_IDLE) || w_bound);
  assign w_rise  = w_busy && w_tick && (r_setup || (r_half[0] && (!w_bound || i_start)));
  assign w_fall  = w_busy && w_tick && !r_setup && !r_half[0];

  // The first rise of a continued slot coincides with the load edge, so it samples with the incoming slot's fields.
  assign w_rx_rw    = w_ld ? (i_rw && !i_dummy) : (r_rw && (r_state == S_SHIFT));
  assign w_rx_q     = w_ld ? i_q_mode : r_q;
  assign w_rx_shift = w_rx_q ? {r_rx[3:0], i_io_in} : {r_rx[6:0], i_io_in[1]};
  assign w_final    = !w_ld && !r_setup && (r_half == w_last_half - HW'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_oe   = 4'h0;
    case (r_state)
      S_IDLE:         if (i_start) w_next = i_dummy ? S_DUMMY : S_SHIFT;
      S_SHIFT,
      S_DUMMY:        if (w_bound) w_next = !i_start ? S_HOLD : (i_dummy ? S_DUMMY : S_SHIFT);
      S_HOLD:         if (w_tick) w_next = S_CSHIGH;
      S_CSHIGH:       if (r_cnt == CSH_LAST) w_next = S_IDLE;
      default:        w_next = S_IDLE;
    endcase
    if (r_state == S_SHIFT && !r_rw) w_oe = r_q ? 4'hF : 4'h1;
  end

  assign o_dload   = w_ld;
  assign o_ready   = (r_state == S_IDLE) && !rst;
  assign o_cs_n    = (r_state == S_IDLE) || (r_state == S_CSHIGH);
  assign o_io_oe   = w_oe;
  assign o_io_out  = (r_q ? r_sh[7:4] : {3'b000, r_sh[7]}) & w_oe;
  assign o_sclk    = r_sclk;
  assign o_dval    = r_dval;
  assign o_rx_data = r_rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE || w_next != r_state || (w_busy && w_tick)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_half    <= '0;
      r_setup   <= 1'b1;
      r_sclk    <= 1'b0;
      r_sh      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_dval    <= 1'b0;
      r_rw      <= 1'b0;
      r_q       <= 1'b0;
    end else begin
      r_dval <= 1'b0;
      if (w_ld) begin
        r_sh <= i_data;
        r_rw <= i_rw && !i_dummy;
        r_q  <= i_q_mode;
      end else if (w_fall) begin
        r_sh <= r_q ? {r_sh[3:0], 4'h0} : {r_sh[6:0], 1'b0};
      end
      if (w_rise && w_rx_rw) begin
        r_rx <= w_rx_shift[6:0];
        if (w_final) begin
          r_rx_data <= w_rx_shift;
          r_dval    <= 1'b1;
        end
      end
      if (r_state == S_IDLE) begin
        r_setup <= 1'b1;
        r_half  <= '0;
        r_sclk  <= 1'b0;
      end else if (w_busy && w_tick) begin
        if (r_setup) begin
          r_setup <= 1'b0;
          r_sclk  <= 1'b1;
          r_half  <= '0;
        end else if (w_bound) begin
          r_half <= '0;
          r_sclk <= i_start;
        end else begin
          r_half <= r_half + HW'(1);
          r_sclk <= ~r_sclk;
        end
      end
    end
  end
endmodule

// File: tb/tb_qspi_shift_engine.sv
// Bench for qspi_shift_engine: frames of slots checked against a per-SCLK model of expected IO, dloads, dvals and CS timing.
module tb_qspi_shift_engine;
  localparam int CLK_DIV = 2;
  localparam int DUMMY   = 8;
  localparam int CSH     = 4;

  logic       clk = 1'b0, rst = 1'b1;
  logic       i_start = 1'b0, i_rw = 1'b0, i_q_mode = 1'b0, i_dummy = 1'b0;
  logic [7:0] i_data = '0;
  logic [3:0] i_io_in = '0;
  logic       o_ready, o_dload, o_dval, o_sclk, o_cs_n;
  logic [7:0] o_rx_data;
  logic [3:0] o_io_out, o_io_oe;

  always #5 clk = ~clk;

  qspi_shift_engine #(.CLK_DIV(CLK_DIV), .DUMMY_CYCLES(DUMMY), .CS_HIGH_CYC(CSH)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data), .i_rw(i_rw),
    .i_q_mode(i_q_mode), .i_dummy(i_dummy), .o_ready(o_ready), .o_dload(o_dload),
    .o_dval(o_dval), .o_rx_data(o_rx_data), .o_sclk(o_sclk), .o_cs_n(o_cs_n),
    .o_io_out(o_io_out), .o_io_oe(o_io_oe), .i_io_in(i_io_in)
  );

  int n_pass = 0, n_total = 0;

  // slot kinds: 0 tx, 1 rx (sl_d is the byte the flash returns), 2 dummy
  int sl_kind[$], sl_q[$], sl_d[$];
  logic [3:0] stream[$];
  logic [3:0] rec_oe[$], rec_io[$];
  logic [7:0] rec_dval[$];
  int n_rise, n_dload, cs_low, cs_falls, hi_cyc;
  logic prev_sclk = 1'b0, prev_cs = 1'b1;

  // Flash/observer: the k-th SCLK rise of a frame samples stream[k].
  initial forever begin
    @(negedge clk);
    if (o_sclk && !prev_sclk) begin
      rec_oe.push_back(o_io_oe);
      rec_io.push_back(o_io_out);
      n_rise++;
    end
    prev_sclk = o_sclk;
    if (!o_cs_n && prev_cs) cs_falls++;
    prev_cs = o_cs_n;
    if (!o_cs_n) cs_low++;
    if (o_cs_n && !o_ready && !rst) hi_cyc++;
    if (o_dload) n_dload++;
    if (o_dval) rec_dval.push_back(o_rx_data);
    i_io_in = (n_rise < stream.size()) ? stream[n_rise] : 4'($urandom);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    rec_oe.delete(); rec_io.delete(); rec_dval.delete();
    n_rise = 0; n_dload = 0; cs_low = 0; cs_falls = 0; hi_cyc = 0;
    prev_cs = o_cs_n; prev_sclk = o_sclk;
  endtask

  task automatic add_slot(input int kind, input int q, input int d);
    sl_kind.push_back(kind); sl_q.push_back(q); sl_d.push_back(d);
  endtask

  task automatic drive_slot(input int i);
    i_start  = 1'b1;
    i_rw     = (sl_kind[i] == 1);
    i_dummy  = (sl_kind[i] == 2);
    i_q_mode = sl_q[i][0];
    i_data   = (sl_kind[i] == 0) ? sl_d[i][7:0] : 8'($urandom);
  endtask

  task automatic run_frame(input string nm);
    int ns, n_sclk, exp_low, idx, guard, bad, hold;
    logic [3:0] exp_oe[$], exp_io[$], io_mask[$];
    logic [7:0] exp_dval[$];
    ns = sl_kind.size(); n_sclk = 0; idx = 0; guard = 0; bad = 0;
    stream.delete();
    for (int s = 0; s < ns; s++) begin
      int n;
      logic [7:0] dd;
      dd = sl_d[s][7:0];
      n = (sl_kind[s] == 2) ? DUMMY : (sl_q[s] != 0 ? 2 : 8);
      if (sl_kind[s] == 1) exp_dval.push_back(dd);
      for (int j = 0; j < n; j++) begin
        logic [3:0] v, nib;
        v = 4'($urandom);
        nib = (j == 0) ? dd[7:4] : dd[3:0];
        if (sl_kind[s] == 1) begin
          if (sl_q[s] != 0) v = nib;
          else v[1] = dd[7-j];
        end
        stream.push_back(v);
        if (sl_kind[s] == 0) begin
          exp_oe.push_back(sl_q[s] != 0 ? 4'hF : 4'h1);
          exp_io.push_back(sl_q[s] != 0 ? nib : {3'b000, dd[7-j]});
          io_mask.push_back(4'hF);
        end else begin
          exp_oe.push_back(4'h0);
          exp_io.push_back(4'h0);
          io_mask.push_back(4'h0);
        end
      end
      n_sclk += n;
    end
    exp_low = 2 * CLK_DIV + 2 * CLK_DIV * n_sclk;

    @(posedge clk); #1;
    clear_mon();
    drive_slot(0);
    while (idx < ns) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        n_total++;
        $display("FAIL %s_timeout: got %0d dloads, required %0d", nm, idx, ns);
        break;
      end
      if (o_dload) begin
        idx++;
        @(posedge clk); #1;
        if (idx < ns) begin
          // brief mid-byte drop of i_start, restored well before the boundary
          drive_slot(idx);
          i_start = 1'b0;
          repeat (2) @(posedge clk);
          #1 i_start = 1'b1;
        end else begin
          hold = $urandom_range(0, 4 * CLK_DIV - 3);
          repeat (hold) @(posedge clk);
          #1 i_start = 1'b0;
        end
      end
    end
    guard = 0;
    while (!o_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    #1;

    n_total++;
    if (!o_ready) $display("FAIL %s_ready: got %b, required 1", nm, o_ready);
    else n_pass++;
    n_total++;
    if (n_dload !== ns) $display("FAIL %s_dload: got %0d, required %0d", nm, n_dload, ns);
    else n_pass++;
    n_total++;
    if (n_rise !== n_sclk) $display("FAIL %s_sclk_rises: got %0d, required %0d", nm, n_rise, n_sclk);
    else n_pass++;
    for (int k = 0; k < exp_oe.size(); k++) begin
      if (k >= rec_oe.size()) bad++;
      else if (rec_oe[k] !== exp_oe[k] || (rec_io[k] & io_mask[k]) !== exp_io[k]) begin
        if (bad == 0) $display("FAIL %s_io rise %0d: got oe=%h io=%h, required oe=%h io=%h",
                               nm, k, rec_oe[k], rec_io[k] & io_mask[k], exp_oe[k], exp_io[k]);
        bad++;
      end
    end
    n_total++;
    if (bad != 0) $display("FAIL %s_io_seq: got %0d bad rises, required 0", nm, bad);
    else n_pass++;
    n_total++;
    if (rec_dval.size() !== exp_dval.size())
      $display("FAIL %s_dval_count: got %0d, required %0d", nm, rec_dval.size(), exp_dval.size());
    else n_pass++;
    bad = 0;
    for (int k = 0; k < exp_dval.size() && k < rec_dval.size(); k++)
      if (rec_dval[k] !== exp_dval[k]) begin
        $display("FAIL %s_rx_data %0d: got %h, required %h", nm, k, rec_dval[k], exp_dval[k]);
        bad++;
      end
    if (exp_dval.size() > 0) begin
      n_total++;
      if (bad != 0) $display("FAIL %s_rx_seq: got %0d bad bytes, required 0", nm, bad);
      else n_pass++;
    end
    n_total++;
    if (cs_low !== exp_low) $display("FAIL %s_cs_low: got %0d cycles, required %0d", nm, cs_low, exp_low);
    else n_pass++;
    n_total++;
    if (cs_falls !== 1) $display("FAIL %s_cs_frames: got %0d, required 1", nm, cs_falls);
    else n_pass++;
    n_total++;
    if (hi_cyc !== CSH) $display("FAIL %s_cs_high: got %0d cycles, required %0d", nm, hi_cyc, CSH);
    else n_pass++;
    sl_kind.delete(); sl_q.delete(); sl_d.delete();
  endtask

  task automatic test_reset();
    i_start = 1'b1;
    @(negedge clk);
    n_total++;
    if ({o_cs_n, o_sclk, o_io_oe, o_io_out} !== 10'b10_0000_0000)
      $display("FAIL rst_outputs: got cs_n=%b sclk=%b oe=%h io=%h, required 1 0 0 0", o_cs_n, o_sclk, o_io_oe, o_io_out);
    else n_pass++;
    n_total++;
    if ({o_dload, o_dval, o_rx_data} !== 10'd0)
      $display("FAIL rst_strobes: got dload=%b dval=%b rx=%h, required 0 0 00", o_dload, o_dval, o_rx_data);
    else n_pass++;
    i_start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (o_ready !== 1'b1 || o_cs_n !== 1'b1) $display("FAIL rst_ready: got ready=%b cs_n=%b, required 1 1", o_ready, o_cs_n);
    else n_pass++;
  endtask

  task automatic test_single_tx();
    add_slot(0, 0, 8'h06);
    run_frame("single_tx");
  endtask

  task automatic test_read_frame();
    add_slot(0, 0, 8'h6B);
    for (int i = 0; i < 3; i++) add_slot(0, 0, int'($urandom_range(0, 255)));
    add_slot(2, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    add_slot(1, 1, 8'hA5);
    run_frame("read_frame");
  endtask

  task automatic test_quad_write();
    add_slot(0, 1, 8'h38);
    for (int i = 0; i < 4; i++) add_slot(0, 1, int'($urandom_range(0, 255)));
    run_frame("quad_write");
  endtask

  task automatic test_single_rx();
    add_slot(1, 0, 8'h3C);
    add_slot(1, 0, 8'h3C);
    run_frame("single_rx");
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int ns;
      ns = $urandom_range(1, 5);
      for (int s = 0; s < ns; s++)
        add_slot(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      run_frame($sformatf("rand%0d", f));
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    i_start = 1'b1; i_q_mode = 1'b1; i_rw = 1'b0; i_dummy = 1'b0; i_data = 8'h38;
    repeat (7) @(posedge clk);
    #2;
    n_total++;
    if (o_cs_n !== 1'b0 || o_io_oe !== 4'hF) $display("FAIL mid_pre: got cs_n=%b oe=%h, required 0 f", o_cs_n, o_io_oe);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (o_cs_n !== 1'b1 || o_io_oe !== 4'h0 || o_sclk !== 1'b0)
      $display("FAIL mid_rst: got cs_n=%b oe=%h sclk=%b, required 1 0 0", o_cs_n, o_io_oe, o_sclk);
    else n_pass++;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (o_ready !== 1'b1 || o_cs_n !== 1'b1) $display("FAIL mid_ready: got ready=%b cs_n=%b, required 1 1", o_ready, o_cs_n);
    else n_pass++;
    #1 clear_mon();
    repeat (10) @(negedge clk);
    #1;
    n_total++;
    if (n_dload !== 0 || rec_dval.size() !== 0)
      $display("FAIL mid_quiet: got dloads=%0d dvals=%0d, required 0 0", n_dload, rec_dval.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_read_frame();
    test_quad_write();
    test_single_rx();
    test_random();
    test_reset_mid();
    test_single_tx();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
